// File: rtl/lcd_hex_formatter.sv
// Periodically snapshots four 16-bit values and writes them as ASCII hex digits into the LCD char buffer.
// Optional build macro LCD_FMT_SKIP_UNCHANGED_EN: suppress writes whose char already matches readData.
module lcd_hex_formatter #(
  parameter int unsigned REFRESH_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] field0,
  input  logic [15:0] field1,
  input  logic [15:0] field2,
  input  logic [15:0] field3,
  input  logic        forceRefresh,
  input  logic [7:0]  readData,
  output logic        writeEnable,
  output logic [4:0]  location,
  output logic [7:0]  data,
  output logic        busy,
  output logic        scanDone
);

  localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_PRESENT, S_COMMIT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0][15:0]  snap_q, snap_d;
  logic              we_q, we_d;
  logic [4:0]        loc_q, loc_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              expire;
  logic              write_ok;
  logic [15:0]       sel_field;
  logic [3:0]        nib;
  logic [7:0]        ascii;

`ifdef LCD_FMT_SKIP_UNCHANGED_EN
  // readData shows the char at the location presented in the previous cycle
  assign write_ok = (readData != data_q);
`else
  logic unused_read_data;
  assign unused_read_data = ^readData;
  assign write_ok = 1'b1;
`endif

  // Digit 0 is the most significant nibble of the selected field
  always_comb begin
    sel_field = snap_q[idx_q[3:2]];
    case (idx_q[1:0])
      2'd0:    nib = sel_field[15:12];
      2'd1:    nib = sel_field[11:8];
      2'd2:    nib = sel_field[7:4];
      default: nib = sel_field[3:0];
    endcase
    ascii = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    we_d      = 1'b0;
    loc_d     = loc_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    expire = (cnt_q == '0);
    cnt_d  = expire ? CNT_RELOAD : (cnt_q - CNT_W'(1));

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (pending_q) begin
          pending_d = 1'b0;
          state_d   = S_SNAP;
        end
      end
      S_SNAP: begin
        snap_d  = {field3, field2, field1, field0};
        idx_d   = '0;
        busy_d  = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        loc_d   = {idx_q[3:2], 1'b0, idx_q[1:0]};
        data_d  = ascii;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        we_d    = write_ok;
        idx_d   = idx_q + 4'd1;
        state_d = (idx_q == 4'd15) ? S_DONE : S_PRESENT;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A request arriving while the current one is being consumed still queues one more scan
    if (expire || forceRefresh) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_RELOAD;
      pending_q <= 1'b1;
      idx_q     <= '0;
      snap_q    <= '0;
      we_q      <= 1'b0;
      loc_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      we_q      <= we_d;
      loc_q     <= loc_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign writeEnable = we_q;
  assign location    = loc_q;
  assign data        = data_q;
  assign busy        = busy_q;
  assign scanDone    = done_q;

endmodule

// File: tb/tb_lcd_hex_formatter.sv
// Scoreboard bench for lcd_hex_formatter: a scan-level timing model predicts every write,
// busy window and scanDone pulse; a negedge monitor compares them against the DUT.
module tb_lcd_hex_formatter;

  localparam int RC = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] field0 = '0, field1 = '0, field2 = '0, field3 = '0;
  logic        forceRefresh = 1'b0;
  logic [7:0]  readData;
  logic        writeEnable;
  logic [4:0]  location;
  logic [7:0]  data;
  logic        busy;
  logic        scanDone;

  lcd_hex_formatter #(.REFRESH_CYCLES(RC)) dut (
    .clk(clk), .reset(reset),
    .field0(field0), .field1(field1), .field2(field2), .field3(field3),
    .forceRefresh(forceRefresh), .readData(readData),
    .writeEnable(writeEnable), .location(location), .data(data),
    .busy(busy), .scanDone(scanDone)
  );

  always #5 clk = ~clk;

  // Behavioural LCD char buffer fed by the DUT's write port
  logic [7:0] lcd_buf [32];
  assign readData = lcd_buf[location];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 32; i++) lcd_buf[i] <= 8'h20;
    else if (writeEnable) lcd_buf[location] <= data;
  end

  typedef struct { int cyc; logic [4:0] loc; logic [7:0] ch; } wr_t;
  wr_t   wr_q[$];
  int    flush_idx = 0;
  int    cyc = 0;
  logic  m_rst_edge = 1'b0;
  logic  m_pend = 1'b0, m_snap_due = 1'b0, m_expire;
  int    m_cnt = 0, m_idle_from = 1 << 30, m_last_snap = -100;
  int    m_busy_end = -1, m_done_cyc = -1;
  logic [15:0] m_fv [4];
  logic [3:0]  m_nib;
  logic [4:0]  m_loc;
  logic [7:0]  m_ch;
  string hex_digits = "0123456789ABCDEF";
  logic [7:0] ref_buf [32];

  int n_tests = 0, n_fail = 0;
  int rd_idx = 0;
  int dir_req = 0, dir_ack = 0;
  logic [7:0] dir_exp [32];
  int tmo_cnt = 0, tmo_seen = 0;

  // Reference model: scan = SNAP at s, write k visible at s+3+2k, scanDone at s+34, IDLE again at s+34
  initial forever begin
    @(posedge clk);
    cyc++;
    m_rst_edge = reset;
    if (reset) begin
      m_pend = 1'b1; m_cnt = RC - 1; m_idle_from = cyc; m_snap_due = 1'b0;
      m_busy_end = -1; m_done_cyc = -1; flush_idx = wr_q.size();
    end else begin
      if (m_snap_due) begin
        m_fv[0] = field0; m_fv[1] = field1; m_fv[2] = field2; m_fv[3] = field3;
        for (int k = 0; k < 16; k++) begin
          m_nib = 4'(m_fv[k / 4] >> (12 - 4 * (k % 4)));
          m_loc = 5'((k / 4) * 8 + (k % 4));
          m_ch  = hex_digits[m_nib];
`ifdef LCD_FMT_SKIP_UNCHANGED_EN
          if (ref_buf[m_loc] != m_ch) wr_q.push_back('{m_last_snap + 3 + 2 * k, m_loc, m_ch});
`else
          wr_q.push_back('{m_last_snap + 3 + 2 * k, m_loc, m_ch});
`endif
        end
        m_snap_due = 1'b0;
      end
      m_expire = (m_cnt == 0);
      m_cnt = m_expire ? RC - 1 : m_cnt - 1;
      if (cyc - 1 >= m_idle_from && m_pend) begin
        m_pend = 1'b0; m_snap_due = 1'b1; m_last_snap = cyc;
        m_busy_end = cyc + 33; m_done_cyc = cyc + 34; m_idle_from = cyc + 34;
      end
      if (m_expire || forceRefresh) m_pend = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: consumes the scoreboard queue and checks every output each cycle
  initial forever begin
    logic exp_we;
    @(negedge clk);
    if (m_rst_edge) for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
    if (rd_idx < flush_idx) rd_idx = flush_idx;
    exp_we = (rd_idx < wr_q.size()) && (wr_q[rd_idx].cyc == cyc);
    check("writeEnable", 32'(writeEnable), 32'(exp_we));
    if (exp_we) begin
      check("location", 32'(location), 32'(wr_q[rd_idx].loc));
      check("data", 32'(data), 32'(wr_q[rd_idx].ch));
      ref_buf[wr_q[rd_idx].loc] = wr_q[rd_idx].ch;
      rd_idx++;
    end
    check("busy", 32'(busy), 32'(cyc > m_last_snap && cyc <= m_busy_end));
    check("scanDone", 32'(scanDone), 32'(cyc == m_done_cyc));
    if (m_rst_edge) begin
      check("reset_location", 32'(location), 32'd0);
      check("reset_data", 32'(data), 32'd0);
    end
    if (dir_req != dir_ack) begin
      for (int i = 0; i < 32; i++) check($sformatf("lcd_buf[%0d]", i), 32'(lcd_buf[i]), 32'(dir_exp[i]));
      dir_ack = dir_req;
    end
    if (tmo_cnt != tmo_seen) begin
      check("wait_bound", 32'(tmo_cnt), 32'(tmo_seen));
      tmo_seen = tmo_cnt;
    end
  end

  task automatic expect_lcd(input string s);
    for (int i = 0; i < 32; i++) dir_exp[i] = s[i];
    dir_req++;
  endtask

  task automatic pulse_force();
    forceRefresh = 1'b1;
    @(negedge clk);
    forceRefresh = 1'b0;
  endtask

  task automatic wait_new_snap();
    int old = m_last_snap;
    int n = 0;
    while (m_last_snap == old && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) tmo_cnt++;
  endtask

  task automatic wait_rel(input int off);
    int n = 0;
    while (cyc != m_last_snap + off && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) tmo_cnt++;
  endtask

  initial begin
    field0 = 16'h1234; field1 = 16'hABCD; field2 = 16'h0000; field3 = 16'hFFFF;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    expect_lcd("1234    ABCD    0000    FFFF    ");

    // Next periodic scan picks up the new field0
    field0 = 16'h09AF;
    repeat (110) @(negedge clk);
    expect_lcd("09AF    ABCD    0000    FFFF    ");

    // Two requests during a scan coalesce into one follow-on scan; mid-scan field edits are ignored
    pulse_force();
    wait_new_snap();
    wait_rel(8);
    pulse_force();
    field1 = 16'(($urandom));
    repeat (5) @(negedge clk);
    pulse_force();
    field2 = 16'(($urandom));
    wait_new_snap();
    repeat (40) @(negedge clk);

    // Randomized fields, requests and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: field0 = 16'($urandom);
          1: field1 = 16'($urandom);
          2: field2 = 16'($urandom);
          default: field3 = 16'($urandom);
        endcase
      end
      forceRefresh = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    forceRefresh = 1'b0;
    reset = 1'b0;

    // Reset right after the 5th write: scan restarts from loc 0 and completes
    field0 = 16'hC0DE; field1 = 16'h5A5A; field2 = 16'h0F0F; field3 = 16'h7777;
    pulse_force();
    wait_new_snap();
    wait_rel(11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    expect_lcd("C0DE    5A5A    0F0F    7777    ");

    repeat (80) @(negedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
